// File: rtl/sort_result_drain.sv
// sort_result_drain: deskews sort-array ranks, buffers whole frames in a FIFO
// and streams them out one word per beat. Define SORT_DRAIN_DESC_EN for descending order.
package sort_pkg;
   localparam int M = 8;
   localparam int N = 8;
   localparam int W = 4;
endpackage

module sort_result_drain
   import sort_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_valid,
   input  logic [W-1:0][N-1:0]             i_y_q,
   output logic [N-1:0]                    o_data,
   output logic [$clog2(W)-1:0]            o_idx,
   output logic                            o_last,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
   output logic                            o_drop,
   output logic [7:0]                      o_drop_cnt
);
   localparam int IW = $clog2(W);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam logic [IW-1:0] BEAT_LAST = IW'(W-1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LVL_ONE = LW'(1);

   typedef enum logic {IDLE, EMIT} state_t;
   typedef logic [W-1:0][N-1:0] frame_t;

   logic [W-1:0]  vsr;
   frame_t        aligned;
   frame_t        mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [IW-1:0] beat;
   logic [IW-1:0] rank;
   state_t        state;
   logic          fire;
   logic          pop;
   logic          full;
   logic          push;
   logic          drop_now;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vsr <= '0;
      else     vsr <= {vsr[W-2:0], i_valid};
   end

   // rank k arrives k+1 cycles after i_valid; delay it so all ranks meet at t+W
   for (genvar k = 0; k < W; k++) begin : g_rank
      localparam int D = W - 1 - k;
      if (D == 0) begin : g_thru
         assign aligned[k] = i_y_q[k];
      end else begin : g_dly
         logic [N-1:0] sr [D];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int j = 0; j < D; j++) sr[j] <= '0;
            end else begin
               sr[0] <= i_y_q[k];
               for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
            end
         end
         assign aligned[k] = sr[D-1];
      end
   end

   assign full     = (level == LVL_FULL);
   assign fire     = o_valid & i_ready;
   assign pop      = fire & o_last;
   assign push     = vsr[W-1] & (~full | pop);
   assign drop_now = vsr[W-1] & ~push;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= aligned;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         o_drop     <= 1'b0;
         o_drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         o_drop <= drop_now;
         if (drop_now && o_drop_cnt != 8'hFF)
            o_drop_cnt <= o_drop_cnt + 1'b1;
      end
   end

   // entering EMIT on the push itself gives first o_valid at t+W+1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         o_valid <= 1'b0;
         beat    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (push || level != '0) begin
                  state   <= EMIT;
                  o_valid <= 1'b1;
               end
            end
            EMIT: begin
               if (fire) begin
                  if (beat == BEAT_LAST) begin
                     beat <= '0;
                     if (level == LVL_ONE && !push) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                     end
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef SORT_DRAIN_DESC_EN
   assign rank = BEAT_LAST - beat;
`else
   assign rank = beat;
`endif

   assign o_data  = o_valid ? mem[rd_ptr][rank] : '0;
   assign o_idx   = o_valid ? rank : '0;
   assign o_last  = o_valid && (beat == BEAT_LAST);
   assign o_level = level;

endmodule

// File: tb/tb_sort_result_drain.sv
// Directed bench for sort_result_drain: table-driven single-frame and
// backpressure vectors, plus overflow, pop+push, and mid-frame reset sequences.
module tb_sort_result_drain;
   import sort_pkg::*;

   localparam int FD = 4;
   localparam int LW = $clog2(FD+1);

   typedef logic [W-1:0][N-1:0] frame_t;
   typedef struct {
      bit start;
      bit vin;
      bit rdy;
      bit ev;
      int eb;
      int elv;
   } vec_t;
   typedef struct {
      logic [N-1:0]         d;
      logic [$clog2(W)-1:0] i;
      logic                 l;
   } beat_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 i_valid = 1'b0;
   logic [W-1:0][N-1:0]  i_y_q = '0;
   logic [N-1:0]         o_data;
   logic [$clog2(W)-1:0] o_idx;
   logic                 o_last;
   logic                 o_valid;
   logic                 i_ready = 1'b0;
   logic [LW-1:0]        o_level;
   logic                 o_drop;
   logic [7:0]           o_drop_cnt;

   always #5 clk = ~clk;

   sort_result_drain #(.FIFO_DEPTH(FD)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (i_valid),
      .i_y_q      (i_y_q),
      .o_data     (o_data),
      .o_idx      (o_idx),
      .o_last     (o_last),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_level    (o_level),
      .o_drop     (o_drop),
      .o_drop_cnt (o_drop_cnt)
   );

   int          n_chk = 0;
   int          n_fail = 0;
   int          c = 0;
   bit          fv [256];
   frame_t      frm [256];
   logic [LW-1:0] lv_log [256];
   bit          dr_log [256];
   logic [7:0]  cnt_log [256];
   bit          ov_log [256];
   frame_t      fa;
   frame_t      fx [6];
   vec_t        tv [$];
   beat_t       exp_q [$];

   function automatic frame_t sort_min(input logic [M-1:0][N-1:0] chi);
      logic [M-1:0][N-1:0] a;
      logic [N-1:0] t;
      frame_t r;
      a = chi;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M-1-i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      for (int k = 0; k < W; k++) r[k] = a[k];
      return r;
   endfunction

   function automatic int rk(input int b);
`ifdef SORT_DRAIN_DESC_EN
      return W - 1 - b;
`else
      return b;
`endif
   endfunction

   function automatic vec_t mk(bit s, bit v, bit r, bit ev, int eb, int elv);
      vec_t x;
      x.start = s; x.vin = v; x.rdy = r; x.ev = ev; x.eb = eb; x.elv = elv;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0d, want %0d", nm, c, act, exp);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 256; i++) fv[i] = 1'b0;
      c = 0;
   endtask

   task automatic step(input bit v, input frame_t f, input bit r);
      fv[c] = v;
      frm[c] = f;
      i_valid = v;
      i_ready = r;
      for (int k = 0; k < W; k++) begin
         automatic int s = c - k - 1;
         i_y_q[k] = (s >= 0 && fv[s]) ? frm[s][k] : 8'hEE;
      end
      @(negedge clk);
      lv_log[c]  = o_level;
      dr_log[c]  = o_drop;
      cnt_log[c] = o_drop_cnt;
      ov_log[c]  = o_valid;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_y_q = '0;
      @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_idx", o_idx, 0);
      chk("rst_last", o_last, 0);
      chk("rst_level", o_level, 0);
      chk("rst_drop", o_drop, 0);
      chk("rst_cnt", o_drop_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr();
   endtask

   task automatic load_exp(input frame_t f);
      beat_t b;
      for (int j = 0; j < W; j++) begin
         b.d = f[rk(j)];
         b.i = rk(j);
         b.l = (j == W-1);
         exp_q.push_back(b);
      end
   endtask

   task automatic drain(input string nm, input int budget);
      beat_t e;
      for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
         step(1'b0, '0, 1'b1);
         if (o_valid) begin
            e = exp_q.pop_front();
            chk({nm, "_data"}, o_data, e.d);
            chk({nm, "_idx"}, o_idx, e.i);
            chk({nm, "_last"}, o_last, e.l);
         end
         adv();
      end
      chk({nm, "_beats_left"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1);
   end

   initial begin
      int np;
      int r;
      fa = sort_min({8'd9, 8'd3, 8'd7, 8'd1, 8'd12, 8'd5, 8'd200, 8'd8});
      for (int i = 0; i < 6; i++)
         for (int k = 0; k < W; k++) fx[i][k] = 8'(16*(i+1) + k + 1);

      // single frame, i_ready held high
      tv.push_back(mk(1, 1, 1, 0, -1, 0));
      repeat (4) tv.push_back(mk(0, 0, 1, 0, -1, 0));
      for (int b = 0; b < W; b++) tv.push_back(mk(0, 0, 1, 1, b, 1));
      tv.push_back(mk(0, 0, 1, 0, -1, 0));
      // backpressure in cycles 6..8
      tv.push_back(mk(1, 1, 1, 0, -1, 0));
      repeat (4) tv.push_back(mk(0, 0, 1, 0, -1, 0));
      tv.push_back(mk(0, 0, 1, 1, 0, 1));
      repeat (3) tv.push_back(mk(0, 0, 0, 1, 1, 1));
      tv.push_back(mk(0, 0, 1, 1, 1, 1));
      tv.push_back(mk(0, 0, 1, 1, 2, 1));
      tv.push_back(mk(0, 0, 1, 1, 3, 1));
      tv.push_back(mk(0, 0, 1, 0, -1, 0));

      foreach (tv[i]) begin
         if (tv[i].start) do_reset();
         step(tv[i].vin, fa, tv[i].rdy);
         chk("tv_valid", o_valid, tv[i].ev);
         chk("tv_level", o_level, tv[i].elv);
         chk("tv_drop", o_drop, 0);
         if (tv[i].ev) begin
            r = rk(tv[i].eb);
            chk("tv_data", o_data, fa[r]);
            chk("tv_idx", o_idx, r);
            chk("tv_last", o_last, tv[i].eb == W-1);
         end else begin
            chk("tv_last_idle", o_last, 0);
         end
         adv();
      end

      // overflow: six back-to-back frames, consumer stalled
      do_reset();
      for (int i = 0; i < 6; i++) begin step(1'b1, fx[i], 1'b0); adv(); end
      repeat (6) begin step(1'b0, '0, 1'b0); adv(); end
      np = 0;
      for (int i = 0; i < 12; i++) begin
         if (dr_log[i]) np++;
         chk("ovf_drop_at", dr_log[i], (i == 9 || i == 10));
      end
      chk("ovf_pulses", np, 2);
      chk("ovf_level_c7", lv_log[7], 3);
      chk("ovf_level_c8", lv_log[8], 4);
      chk("ovf_level_c11", lv_log[11], 4);
      chk("ovf_cnt_c9", cnt_log[9], 1);
      chk("ovf_cnt_c11", cnt_log[11], 2);
      chk("ovf_valid_c4", ov_log[4], 0);
      chk("ovf_valid_c5", ov_log[5], 1);
      for (int i = 0; i < 4; i++) load_exp(fx[i]);
      drain("ovf", 40);
      step(1'b0, '0, 1'b1);
      chk("ovf_end_valid", o_valid, 0);
      chk("ovf_end_level", o_level, 0);
      chk("ovf_end_cnt", o_drop_cnt, 2);
      adv();

      // full FIFO, last beat popped in the cycle a new frame aligns
      do_reset();
      for (int i = 0; i < 4; i++) begin step(1'b1, fx[i], 1'b0); adv(); end
      repeat (3) begin step(1'b0, '0, 1'b0); adv(); end
      step(1'b1, fx[4], 1'b0);
      adv();
      for (int i = 0; i < 5; i++) load_exp(fx[i]);
      drain("pp", 40);
      chk("pp_level_c11", lv_log[11], 4);
      chk("pp_level_c12", lv_log[12], 4);
      np = 0;
      for (int i = 0; i < c; i++) if (dr_log[i]) np++;
      chk("pp_no_drop", np, 0);
      chk("pp_cnt", o_drop_cnt, 0);

      // reset during beat 2 of a frame
      do_reset();
      for (int i = 0; i < 6; i++) begin step(1'b1, fx[i], 1'b0); adv(); end
      repeat (6) begin step(1'b0, '0, 1'b0); adv(); end
      step(1'b0, '0, 1'b1); adv();
      step(1'b0, '0, 1'b1); adv();
      step(1'b0, '0, 1'b1);
      chk("mid_idx_b2", o_idx, rk(2));
      chk("mid_cnt_pre", o_drop_cnt, 2);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_valid", o_valid, 0);
      chk("mid_level", o_level, 0);
      chk("mid_cnt", o_drop_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr();
      np = 0;
      repeat (12) begin
         step(1'b0, '0, 1'b1);
         if (o_valid) np++;
         adv();
      end
      chk("mid_stale_beats", np, 0);
      chk("mid_level_after", o_level, 0);
      step(1'b1, fa, 1'b1);
      adv();
      load_exp(fa);
      drain("post", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
